// File: rtl/vx_muldiv_arb.sv
// Shares one integer multiply/divide unit among several issue requesters: round-robin
// grant with locking, uuid-to-slot-tag remapping, and tag-based response demultiplexing.
module vx_muldiv_arb #(
    parameter int UUID_BITS     = 44,
    parameter int INST_MUL_BITS = 3,
    parameter int NW_BITS       = 2,
    parameter int NUM_THREADS   = 4,
    parameter int NR_BITS       = 5,
    parameter int REQS          = 2,
    parameter int SLOTS         = 8,
    parameter int TAG_W         = $clog2(SLOTS),
    parameter int REQ_W         = INST_MUL_BITS + NW_BITS + NUM_THREADS + 32 + NR_BITS + 1
                                  + 2 * NUM_THREADS * 32,
    parameter int RSP_W         = NW_BITS + NUM_THREADS + 32 + NR_BITS + 1 + NUM_THREADS * 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [REQS-1:0]                    req_valid,
    output logic [REQS-1:0]                    req_ready,
    input  logic [REQS-1:0][UUID_BITS-1:0]     req_uuid,
    input  logic [REQS-1:0][REQ_W-1:0]         req_payload,
    output logic                               mdu_valid_in,
    input  logic                               mdu_ready_in,
    output logic [UUID_BITS-1:0]               mdu_uuid_in,
    output logic [REQ_W-1:0]                   mdu_payload,
    input  logic                               mdu_valid_out,
    output logic                               mdu_ready_out,
    input  logic [UUID_BITS-1:0]               mdu_uuid_out,
    input  logic [RSP_W-1:0]                   mdu_rsp,
    output logic [REQS-1:0]                    rsp_valid,
    input  logic [REQS-1:0]                    rsp_ready,
    output logic [UUID_BITS-1:0]               rsp_uuid,
    output logic [RSP_W-1:0]                   rsp_payload,
    output logic [$clog2(SLOTS+1)-1:0]         inflight,
    output logic                               tag_err
);

    localparam int OWN_W = (REQS > 1) ? $clog2(REQS) : 1;
    localparam int CNT_W = $clog2(SLOTS + 1);

    // Valid/ready: a transfer happens on a side only in a cycle where both valid and
    // ready are high; a presented request keeps its grant (lock) until it transfers.

    logic [SLOTS-1:0]     busy;
    logic [OWN_W-1:0]     owner    [SLOTS];
    logic [UUID_BITS-1:0] uuid_tab [SLOTS];

    logic [OWN_W-1:0]     ptr;
    logic [OWN_W-1:0]     lock_id;
    logic                 lock_v;

    logic                 slot_avail;
    logic [TAG_W-1:0]     alloc_tag;
    logic [OWN_W-1:0]     win_id;
    logic                 win_found;
    logic                 win_valid;
    logic [OWN_W-1:0]     ptr_next;
    logic                 issue_fire;
    int                   idx;

    logic [TAG_W-1:0]     rsp_tag;
    logic                 rsp_busy;
    logic [OWN_W-1:0]     rsp_owner;
    logic                 rsp_fire;

    // Lowest-index free slot, from the registered busy bits only.
    always_comb begin
        slot_avail = 1'b0;
        alloc_tag  = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (!busy[s]) begin
                slot_avail = 1'b1;
                alloc_tag  = TAG_W'(s);
            end
        end
    end

    always_comb begin
        win_id    = ptr;
        win_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < REQS; i++) begin
            idx = (int'(ptr) + i) % REQS;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = OWN_W'(idx);
            end
        end
        if (lock_v) win_id = lock_id;
        win_valid = req_valid[win_id];
        ptr_next  = OWN_W'((int'(win_id) + 1) % REQS);
    end

    always_comb begin
        mdu_valid_in = win_valid && slot_avail;
        mdu_uuid_in  = UUID_BITS'(alloc_tag);
        mdu_payload  = req_payload[win_id];
        req_ready    = '0;
        if (slot_avail && mdu_ready_in) req_ready[win_id] = 1'b1;
        issue_fire   = mdu_valid_in && mdu_ready_in;
    end

    // A response whose slot is free is drained unconditionally and flagged.
    always_comb begin
        rsp_tag       = mdu_uuid_out[TAG_W-1:0];
        rsp_busy      = busy[rsp_tag];
        rsp_owner     = owner[rsp_tag];
        rsp_uuid      = uuid_tab[rsp_tag];
        rsp_payload   = mdu_rsp;
        rsp_valid     = '0;
        if (mdu_valid_out && rsp_busy) rsp_valid[rsp_owner] = 1'b1;
        mdu_ready_out = rsp_busy ? rsp_ready[rsp_owner] : 1'b1;
        rsp_fire      = mdu_valid_out && rsp_busy && rsp_ready[rsp_owner];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            ptr      <= '0;
            lock_v   <= 1'b0;
            lock_id  <= '0;
            inflight <= '0;
            tag_err  <= 1'b0;
        end else begin
            if (issue_fire) begin
                busy[alloc_tag] <= 1'b1;
                ptr             <= ptr_next;
            end
            if (rsp_fire) busy[rsp_tag] <= 1'b0;
            lock_v <= win_valid && !issue_fire;
            if (win_valid && !issue_fire) lock_id <= win_id;
            inflight <= inflight + CNT_W'(issue_fire) - CNT_W'(rsp_fire);
            if (mdu_valid_out && !rsp_busy) tag_err <= 1'b1;
        end
    end

    // Owner/uuid contents are only meaningful while busy, so they need no reset.
    always_ff @(posedge clk) begin
        if (issue_fire) begin
            owner[alloc_tag]    <= win_id;
            uuid_tab[alloc_tag] <= req_uuid[win_id];
        end
    end

endmodule

// File: tb/tb_vx_muldiv_arb.sv
// Directed bench for vx_muldiv_arb: the bench plays both the requesters and the MUL/DIV unit.
module tb_vx_muldiv_arb;

    localparam int UUID_BITS     = 16;
    localparam int INST_MUL_BITS = 3;
    localparam int NW_BITS       = 2;
    localparam int NUM_THREADS   = 1;
    localparam int NR_BITS       = 5;
    localparam int REQS          = 2;
    localparam int SLOTS         = 8;
    localparam int TAG_W         = 3;
    localparam int REQ_W = INST_MUL_BITS + NW_BITS + NUM_THREADS + 32 + NR_BITS + 1 + 2 * NUM_THREADS * 32;
    localparam int RSP_W = NW_BITS + NUM_THREADS + 32 + NR_BITS + 1 + NUM_THREADS * 32;

    logic                           clk;
    logic                           reset;
    logic [REQS-1:0]                req_valid;
    logic [REQS-1:0]                req_ready;
    logic [REQS-1:0][UUID_BITS-1:0] req_uuid;
    logic [REQS-1:0][REQ_W-1:0]     req_payload;
    logic                           mdu_valid_in;
    logic                           mdu_ready_in;
    logic [UUID_BITS-1:0]           mdu_uuid_in;
    logic [REQ_W-1:0]               mdu_payload;
    logic                           mdu_valid_out;
    logic                           mdu_ready_out;
    logic [UUID_BITS-1:0]           mdu_uuid_out;
    logic [RSP_W-1:0]               mdu_rsp;
    logic [REQS-1:0]                rsp_valid;
    logic [REQS-1:0]                rsp_ready;
    logic [UUID_BITS-1:0]           rsp_uuid;
    logic [RSP_W-1:0]               rsp_payload;
    logic [$clog2(SLOTS+1)-1:0]     inflight;
    logic                           tag_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [UUID_BITS-1:0] exp_q[$];

    vx_muldiv_arb #(
        .UUID_BITS(UUID_BITS), .INST_MUL_BITS(INST_MUL_BITS), .NW_BITS(NW_BITS),
        .NUM_THREADS(NUM_THREADS), .NR_BITS(NR_BITS), .REQS(REQS), .SLOTS(SLOTS),
        .TAG_W(TAG_W), .REQ_W(REQ_W), .RSP_W(RSP_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid), .req_payload(req_payload),
        .mdu_valid_in(mdu_valid_in), .mdu_ready_in(mdu_ready_in), .mdu_uuid_in(mdu_uuid_in),
        .mdu_payload(mdu_payload), .mdu_valid_out(mdu_valid_out), .mdu_ready_out(mdu_ready_out),
        .mdu_uuid_out(mdu_uuid_out), .mdu_rsp(mdu_rsp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid), .rsp_payload(rsp_payload),
        .inflight(inflight), .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [REQ_W-1:0] mk_pay(input logic [2:0] op, input logic [15:0] id);
        mk_pay = REQ_W'({op, 16'hC0DE, id, 32'h0BAD_BEEF, id, 16'h5A5A});
    endfunction

    initial begin
        logic [RSP_W-1:0] rsp_val;
        int w;

        reset         = 1'b0;
        req_valid     = '0;
        req_uuid      = '0;
        req_payload   = '0;
        mdu_ready_in  = 1'b0;
        mdu_valid_out = 1'b1;
        mdu_uuid_out  = '0;
        mdu_rsp       = '0;
        rsp_ready     = 2'b11;

        // Reset state: every slot free, so a response cannot be routed.
        #3;
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_inflight", inflight, 0);
        check("rst_tag_err", tag_err, 0);
        check("rst_mdu_ready_out", mdu_ready_out, 1);
        step();
        mdu_valid_out = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Both requesters issue MUL continuously: grants alternate 0,1,0,1.
        req_uuid[0]    = 16'h11;
        req_uuid[1]    = 16'h22;
        req_payload[0] = mk_pay(3'd0, 16'h0011);
        req_payload[1] = mk_pay(3'd0, 16'h0022);
        req_valid      = 2'b11;
        mdu_ready_in   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = k % 2;
            settle();
            check("rr_req_ready", req_ready, (w == 1) ? 2'b10 : 2'b01);
            check("rr_tag", mdu_uuid_in, 128'(k));
            check("rr_payload", mdu_payload, req_payload[w]);
            exp_q.push_back(req_uuid[w]);
            step();
            req_uuid[w] = req_uuid[w] + 16'h22;
        end
        req_valid = 2'b00;
        settle();
        check("rr_inflight", inflight, 4);
        for (int k = 0; k < 4; k++) begin
            rsp_val       = RSP_W'({16'hBEEF, 16'(k)});
            mdu_rsp       = rsp_val;
            mdu_uuid_out  = 16'(k);
            mdu_valid_out = 1'b1;
            settle();
            check("rr_rsp_valid", rsp_valid, (k % 2 == 1) ? 2'b10 : 2'b01);
            check("rr_rsp_uuid", rsp_uuid, exp_q.pop_front());
            check("rr_rsp_payload", rsp_payload, rsp_val);
            step();
        end
        mdu_valid_out = 1'b0;
        settle();
        check("rr_drained", inflight, 0);

        // Move ptr to 1 with a lone req0 issue (slot 0).
        req_uuid[0]    = 16'h0A;
        req_payload[0] = mk_pay(3'd0, 16'h000A);
        req_valid      = 2'b01;
        settle();
        check("pre_lock_ready", req_ready, 2'b01);
        step();

        // DIV on req0 held off 5 cycles; req1 joins but must not steal the grant.
        req_uuid[0]    = 16'h55;
        req_payload[0] = mk_pay(3'd4, 16'h0055);
        req_uuid[1]    = 16'h66;
        req_payload[1] = mk_pay(3'd0, 16'h0066);
        mdu_ready_in   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 0) ? 2'b01 : 2'b11;
            settle();
            check("lock_valid_in", mdu_valid_in, 1);
            check("lock_req_ready", req_ready, 2'b00);
            check("lock_payload", mdu_payload, mk_pay(3'd4, 16'h0055));
            step();
        end
        mdu_ready_in = 1'b1;
        settle();
        check("lock_fire_ready", req_ready, 2'b01);
        check("lock_fire_tag", mdu_uuid_in, 1);
        step();
        req_uuid[0]    = 16'h77;
        req_payload[0] = mk_pay(3'd0, 16'h0077);
        settle();
        check("ptr_after_lock", req_ready, 2'b10);
        check("ptr_after_tag", mdu_uuid_in, 2);
        check("ptr_after_payload", mdu_payload, mk_pay(3'd0, 16'h0066));
        step();
        req_valid = 2'b00;

        // Out-of-order completion: MUL tag 2 first, then DIV tag 1, then tag 0.
        mdu_valid_out = 1'b1;
        mdu_uuid_out  = 16'd2;
        settle();
        check("ooo_valid_t2", rsp_valid, 2'b10);
        check("ooo_uuid_t2", rsp_uuid, 16'h66);
        step();
        mdu_uuid_out = 16'd1;
        settle();
        check("ooo_valid_t1", rsp_valid, 2'b01);
        check("ooo_uuid_t1", rsp_uuid, 16'h55);
        step();
        mdu_uuid_out = 16'd0;
        settle();
        check("ooo_valid_t0", rsp_valid, 2'b01);
        check("ooo_uuid_t0", rsp_uuid, 16'h0A);
        step();
        mdu_valid_out = 1'b0;
        settle();
        check("ooo_inflight", inflight, 0);

        // Response backpressure from its owner for 3 cycles.
        req_uuid[1] = 16'h99;
        req_valid   = 2'b10;
        settle();
        check("bp_issue_ready", req_ready, 2'b10);
        check("bp_issue_tag", mdu_uuid_in, 0);
        step();
        req_valid     = 2'b00;
        mdu_valid_out = 1'b1;
        mdu_uuid_out  = 16'd0;
        rsp_ready     = 2'b01;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("bp_ready_out", mdu_ready_out, 0);
            check("bp_rsp_valid", rsp_valid, 2'b10);
            check("bp_inflight", inflight, 1);
            step();
        end
        rsp_ready = 2'b11;
        settle();
        check("bp_release", mdu_ready_out, 1);
        check("bp_release_uuid", rsp_uuid, 16'h99);
        step();
        mdu_valid_out = 1'b0;
        settle();
        check("bp_one_fire", inflight, 0);
        check("bp_no_tag_err", tag_err, 0);

        // Fill all slots with responses withheld.
        req_valid = 2'b01;
        for (int k = 0; k < SLOTS; k++) begin
            req_uuid[0] = 16'h100 + 16'(k);
            settle();
            check("fill_tag", mdu_uuid_in, 128'(k));
            check("fill_ready", req_ready, 2'b01);
            step();
        end
        settle();
        check("full_inflight", inflight, SLOTS);
        check("full_valid_in", mdu_valid_in, 0);
        check("full_req_ready", req_ready, 2'b00);
        mdu_valid_out = 1'b1;
        mdu_uuid_out  = 16'd2;
        #1;
        check("full_rsp_uuid", rsp_uuid, 16'h102);
        check("full_rsp_valid", rsp_valid, 2'b01);
        check("full_same_cycle_ready", req_ready, 2'b00);
        step();
        mdu_valid_out = 1'b0;
        req_uuid[0]   = 16'h1F2;
        settle();
        check("full_freed_inflight", inflight, SLOTS - 1);
        check("full_realloc_tag", mdu_uuid_in, 2);
        check("full_realloc_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        settle();
        check("full_again", inflight, SLOTS);
        for (int k = 0; k < SLOTS; k++) begin
            mdu_valid_out = 1'b1;
            mdu_uuid_out  = 16'(k);
            settle();
            check("drain_valid", rsp_valid, 2'b01);
            check("drain_uuid", rsp_uuid, (k == 2) ? 16'h1F2 : 16'h100 + 16'(k));
            step();
        end
        mdu_valid_out = 1'b0;
        settle();
        check("drain_inflight", inflight, 0);

        // Stale response on free slot 5.
        mdu_valid_out = 1'b1;
        mdu_uuid_out  = 16'd5;
        settle();
        check("stale_ready_out", mdu_ready_out, 1);
        check("stale_rsp_valid", rsp_valid, 2'b00);
        check("stale_err_before", tag_err, 0);
        step();
        settle();
        check("stale_err_set", tag_err, 1);
        mdu_valid_out = 1'b0;
        step();
        settle();
        check("stale_err_sticky", tag_err, 1);

        // Asynchronous reset in the middle of traffic.
        step();
        req_valid    = 2'b11;
        mdu_ready_in = 1'b1;
        step();
        step();
        settle();
        check("mid_inflight", inflight, 2);
        mdu_valid_out = 1'b1;
        mdu_uuid_out  = 16'd0;
        reset         = 1'b0;
        #1;
        check("async_inflight", inflight, 0);
        check("async_tag_err", tag_err, 0);
        check("async_rsp_valid", rsp_valid, 2'b00);
        req_valid     = 2'b00;
        mdu_valid_out = 1'b0;
        step();
        reset = 1'b1;
        step();
        settle();
        check("post_reset_inflight", inflight, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
